duty_ramp_ctrl: RTL and testbench



---
 rtl/fan_ctrl_pkg.sv | 19 +
 rtl/duty_step_calc.sv | 41 ++++
 rtl/duty_ramp_ctrl.sv | 126 ++++++++++++
 tb/tb_duty_ramp_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared fan-controller definitions: ramp FSM state encoding and the default
// duty width, which the PWM stage uses as well.
package fan_ctrl_pkg;

    localparam int DUTY_W_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_KICK_ENC = 2'd1;
    localparam logic [1:0] ST_RAMP_ENC = 2'd2;
    localparam logic [1:0] ST_HOLD_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_KICK = ST_KICK_ENC,
        ST_RAMP = ST_RAMP_ENC,
        ST_HOLD = ST_HOLD_ENC
    } ramp_state_t;

endpackage

// File: rtl/duty_step_calc.sv
// Combinational saturating step of a duty value toward a target. The result
// never overshoots or wraps, and a step larger than the remaining distance
// lands exactly on the target.
module duty_step_calc #(
    parameter int COUNTER_BITWIDTH = fan_ctrl_pkg::DUTY_W_DEFAULT,
    parameter int STEP_SIZE        = 4
) (
    input  logic [COUNTER_BITWIDTH-1:0] duty,
    input  logic [COUNTER_BITWIDTH-1:0] target,
    output logic [COUNTER_BITWIDTH-1:0] new_duty,
    output logic                        reached
);

    localparam int W = COUNTER_BITWIDTH;
    localparam logic [W:0] STEP = (W+1)'(STEP_SIZE);

    logic [W:0] duty_ext;
    logic [W:0] tgt_ext;
    logic [W:0] up;
    logic [W:0] dn;

    assign duty_ext = {1'b0, duty};
    assign tgt_ext  = {1'b0, target};
    assign up       = duty_ext + STEP;
    assign dn       = duty_ext - STEP;

    // dn[W] set means the subtraction went below zero
    always_comb begin
        new_duty = target;
        if (duty < target) begin
            if (up < tgt_ext) new_duty = up[W-1:0];
        end else if (duty > target) begin
            if (!dn[W] && (dn > tgt_ext)) new_duty = dn[W-1:0];
        end else begin
            new_duty = duty;
        end
    end

    assign reached = (new_duty == target);

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Duty-setpoint conditioner feeding the PWM compare: slew-limited ramp with an
// optional full-scale kick-start from standstill (DUTY_RAMP_KICKSTART_EN).
//
// state | meaning
// IDLE  | duty 0, fan stopped, waiting for a nonzero target
// KICK  | duty all-ones for KICK_STEPS step events (kick-start builds only)
// RAMP  | stepping duty toward target
// HOLD  | duty equals target
module duty_ramp_ctrl #(
    parameter int COUNTER_BITWIDTH = fan_ctrl_pkg::DUTY_W_DEFAULT,
    parameter int STEP_SIZE        = 4,
    parameter int KICK_STEPS       = 16
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clk_en_i,
    input  logic                        step_i,
    input  logic [COUNTER_BITWIDTH-1:0] target_i,
    output logic [COUNTER_BITWIDTH-1:0] duty_o,
    output logic                        settled_o,
    output logic                        kick_o
);

    import fan_ctrl_pkg::*;

    localparam int W = COUNTER_BITWIDTH;

    ramp_state_t state_q, state_d;
    logic [W-1:0] duty_q, duty_d;
    logic [W-1:0] step_duty;
    logic         step_reached;
    logic         step_ev;

    assign step_ev = clk_en_i & step_i;

    duty_step_calc #(
        .COUNTER_BITWIDTH(W),
        .STEP_SIZE       (STEP_SIZE)
    ) u_step (
        .duty    (duty_q),
        .target  (target_i),
        .new_duty(step_duty),
        .reached (step_reached)
    );

`ifdef DUTY_RAMP_KICKSTART_EN
    localparam int CW = $clog2(KICK_STEPS + 1);
    localparam logic [CW-1:0] KICK_INIT = CW'(KICK_STEPS - 1);

    logic [CW-1:0] kick_cnt_q, kick_cnt_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) kick_cnt_q <= '0;
        else         kick_cnt_q <= kick_cnt_d;
    end
`else
    logic unused_kick_steps;
    assign unused_kick_steps = (KICK_STEPS > 0);
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
`ifdef DUTY_RAMP_KICKSTART_EN
        kick_cnt_d = kick_cnt_q;
`endif
        if (step_ev) begin
            case (state_q)
                ST_IDLE: begin
                    if (target_i != '0) begin
`ifdef DUTY_RAMP_KICKSTART_EN
                        state_d    = ST_KICK;
                        duty_d     = '1;
                        kick_cnt_d = KICK_INIT;
`else
                        duty_d  = step_duty;
                        state_d = step_reached ? ST_HOLD : ST_RAMP;
`endif
                    end
                end
`ifdef DUTY_RAMP_KICKSTART_EN
                ST_KICK: begin
                    if (target_i == '0) begin
                        duty_d  = '0;
                        state_d = ST_IDLE;
                    end else if (kick_cnt_q == '0) begin
                        duty_d  = step_duty;
                        state_d = step_reached ? ST_HOLD : ST_RAMP;
                    end else begin
                        kick_cnt_d = kick_cnt_q - 1'b1;
                    end
                end
`endif
                ST_RAMP, ST_HOLD: begin
                    duty_d = step_duty;
                    if ((step_duty == '0) && (target_i == '0)) state_d = ST_IDLE;
                    else if (step_reached)                      state_d = ST_HOLD;
                    else                                        state_d = ST_RAMP;
                end
                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    assign duty_o    = duty_q;
    assign settled_o = (state_q == ST_IDLE) || (state_q == ST_HOLD);
`ifdef DUTY_RAMP_KICKSTART_EN
    assign kick_o    = (state_q == ST_KICK);
`else
    assign kick_o    = 1'b0;
`endif

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl; covers both DUTY_RAMP_KICKSTART_EN builds.
module tb_duty_ramp_ctrl;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       clk_en_i = 1'b0;
    logic       step_i = 1'b0;
    logic [7:0] target_i = 8'h00;
    logic [7:0] duty_o;
    logic       settled_o;
    logic       kick_o;

    int total = 0;
    int bad   = 0;

    duty_ramp_ctrl #(
        .COUNTER_BITWIDTH(8),
        .STEP_SIZE       (4),
        .KICK_STEPS      (4)
    ) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clk_en_i (clk_en_i),
        .step_i   (step_i),
        .target_i (target_i),
        .duty_o   (duty_o),
        .settled_o(settled_o),
        .kick_o   (kick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic s, input logic k);
        check({tag, ".duty"},    32'(duty_o),    32'(d));
        check({tag, ".settled"}, 32'(settled_o), 32'(s));
        check({tag, ".kick"},    32'(kick_o),    32'(k));
    endtask

    // one step event sampled on the posedge between two negedges
    task automatic do_step(input logic [7:0] tgt);
        @(negedge clk_i);
        target_i = tgt;
        clk_en_i = 1'b1;
        step_i   = 1'b1;
        @(negedge clk_i);
        clk_en_i = 1'b0;
        step_i   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_d;

        #12;
        check_out("reset", 8'h00, 1'b1, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // step_i without clock enable is ignored
        target_i = 8'h40;
        step_i   = 1'b1;
        clk_en_i = 1'b0;
        repeat (10) @(negedge clk_i);
        step_i = 1'b0;
        check_out("no_clk_en", 8'h00, 1'b1, 1'b0);

`ifdef DUTY_RAMP_KICKSTART_EN
        for (int i = 1; i <= 4; i++) begin
            do_step(8'h40);
            check_out($sformatf("kick%0d", i), 8'hFF, 1'b0, 1'b1);
        end
        // 48 ramp steps from 0xFF down to 0x40, last one clamped
        for (int k = 1; k <= 48; k++) begin
            do_step(8'h40);
            exp_d = (k < 48) ? 8'(255 - 4 * k) : 8'h40;
            if (k == 1 || k == 47 || k == 48)
                check_out($sformatf("ramp_dn%0d", k), exp_d, (k == 48), 1'b0);
            else
                check($sformatf("ramp_dn%0d.duty", k), 32'(duty_o), 32'(exp_d));
        end
        do_step(8'h4A); check_out("up44", 8'h44, 1'b0, 1'b0);
        do_step(8'h4A); check_out("up48", 8'h48, 1'b0, 1'b0);
        do_step(8'h4A); check_out("up4A", 8'h4A, 1'b1, 1'b0);

        // async reset mid-KICK
        do_reset();
        do_step(8'h20); check_out("k2_entry", 8'hFF, 1'b0, 1'b1);
        do_step(8'h20);
        #2 rstn_i = 1'b0;
        #1 check_out("rst_mid_kick", 8'h00, 1'b1, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        do_step(8'h20); check_out("rekick", 8'hFF, 1'b0, 1'b1);
        do_step(8'h00); check_out("abort", 8'h00, 1'b1, 1'b0);
        do_step(8'h00); check_out("idle_zero", 8'h00, 1'b1, 1'b0);

        // full-scale target: kick then already at target
        for (int i = 1; i <= 4; i++) do_step(8'hFF);
        check_out("ff_kick4", 8'hFF, 1'b0, 1'b1);
        do_step(8'hFF); check_out("ff_hold", 8'hFF, 1'b1, 1'b0);
`else
        do_step(8'h10); check_out("nk04", 8'h04, 1'b0, 1'b0);
        do_step(8'h10); check_out("nk08", 8'h08, 1'b0, 1'b0);
        do_step(8'h10); check_out("nk0C", 8'h0C, 1'b0, 1'b0);
        do_step(8'h10); check_out("nk10", 8'h10, 1'b1, 1'b0);
        do_step(8'h10); check_out("nk_hold", 8'h10, 1'b1, 1'b0);
        do_step(8'h00); check_out("dn0C", 8'h0C, 1'b0, 1'b0);
        do_step(8'h00); check_out("dn08", 8'h08, 1'b0, 1'b0);
        do_step(8'h00); check_out("dn04", 8'h04, 1'b0, 1'b0);
        do_step(8'h00); check_out("dn00", 8'h00, 1'b1, 1'b0);
        do_step(8'h0A); check_out("c04", 8'h04, 1'b0, 1'b0);
        do_step(8'h0A); check_out("c08", 8'h08, 1'b0, 1'b0);
        do_step(8'h0A); check_out("c0A", 8'h0A, 1'b1, 1'b0);
        // redirect mid-ramp from current duty
        do_reset();
        do_step(8'h20); check_out("r04", 8'h04, 1'b0, 1'b0);
        do_step(8'h20); check_out("r08", 8'h08, 1'b0, 1'b0);
        do_step(8'h06); check_out("r06", 8'h06, 1'b1, 1'b0);
        // async reset mid-RAMP
        do_step(8'h40);
        #2 rstn_i = 1'b0;
        #1 check_out("rst_mid_ramp", 8'h00, 1'b1, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        do_step(8'h20); check_out("after_rst", 8'h04, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
